// File: rtl/tinyqv_fetch_pkg.sv
// tinyqv_fetch_pkg
// Shared definitions for the TinyQV instruction prefetch path:
//   - fetch_state_e : prefetch FSM encoding (IDLE, REQ, RUN)
//   - HW_W          : halfword width
//   - is_compressed : RVC detect on the low halfword of an instruction
package tinyqv_fetch_pkg;

    localparam int HW_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2
    } fetch_state_e;

    // An RV32IC instruction is 16-bit unless its two low bits are both set.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/tinyqv_hw_fifo.sv
// tinyqv_hw_fifo
// Halfword queue for the prefetch buffer. Exposes the two oldest entries
// combinationally so the top level can assemble a 16- or 32-bit window.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (pointers/count only)
//   flush_i        drop all entries (wins over push/pop)
//   push_i         write push_data_i at the tail (caller guarantees not full)
//   push_data_i    halfword to write
//   pop_cnt_i      0, 1 or 2 entries to remove from the head
//   head0_o        oldest entry
//   head1_o        entry after the oldest
//   count_o        number of valid entries, 0..DEPTH
module tinyqv_hw_fifo
    import tinyqv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [HW_W-1:0]            push_data_i,
    input  logic [1:0]                 pop_cnt_i,
    output logic [HW_W-1:0]            head0_o,
    output logic [HW_W-1:0]            head1_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage is deliberately not reset; count gates every use of it.
    logic [HW_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [PW-1:0] rd_ptr_p1;

    logic do_push;

    assign do_push   = push_i && !flush_i;
    assign rd_ptr_p1 = rd_ptr_q + PW'(1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(pop_cnt_i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head0_o = mem_q[rd_ptr_q];
    assign head1_o = mem_q[rd_ptr_p1];
    assign count_o = count_q;

endmodule

// File: rtl/tinyqv_instr_prefetch.sv
// tinyqv_instr_prefetch
// Prefetch buffer between the TinyQV decoder and the memory controller's
// instruction port. Requests a fetch stream, queues incoming halfwords and
// presents one aligned 16/32-bit instruction window with its PC.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   pc_load, pc_load_addr     flush and restart fetch at a new PC [23:1]
//   instr_take                core consumes the current instruction
//   instr_out/valid/compressed/pc   instruction window to the core
//   instr_addr                next halfword fetch address [23:1]
//   instr_fetch_restart       request a new stream from instr_addr
//   instr_fetch_stall         ask the controller to hold off
//   instr_fetch_started/stopped     controller stream status pulses
//   instr_data, instr_ready   fetched halfword and its strobe
module tinyqv_instr_prefetch
    import tinyqv_fetch_pkg::*;
#(
    parameter int          DEPTH_HW   = 4,
    parameter logic [22:0] RESET_ADDR = 23'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pc_load,
    input  logic [22:0] pc_load_addr,
    input  logic        instr_take,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        instr_compressed,
    output logic [22:0] instr_pc,
    output logic [22:0] instr_addr,
    output logic        instr_fetch_restart,
    output logic        instr_fetch_stall,
    input  logic        instr_fetch_started,
    input  logic        instr_fetch_stopped,
    input  logic [15:0] instr_data,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH_HW) + 1;

    fetch_state_e state_q, state_d;
    logic [22:0]  pc_q, pc_d;
    logic [22:0]  fetch_pc_q, fetch_pc_d;

    logic [HW_W-1:0] head0, head1;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic            head_compressed;
    logic            full;
    logic            take;
    logic            push;
    logic [1:0]      pop_cnt;

    // Storage is not reset, so the compressed flag only means something
    // once the head entry holds real data.
    assign head_compressed = (count != '0) && is_compressed(head0);
    assign instr_valid     = (count >= CW'(2)) || head_compressed;
    assign full            = (count == CW'(DEPTH_HW));

    // pc_load overrides take and push in the same cycle.
    assign take    = instr_take && instr_valid && !pc_load;
    assign pop_cnt = take ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
    // A ready with the queue full is a controller protocol error: dropped.
    assign push    = (state_q == ST_RUN) && instr_ready && !full && !pc_load;

    assign count_after = count + CW'(push) - CW'(pop_cnt);

    tinyqv_hw_fifo #(
        .DEPTH(DEPTH_HW)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (pc_load),
        .push_i     (push),
        .push_data_i(instr_data),
        .pop_cnt_i  (pop_cnt),
        .head0_o    (head0),
        .head1_o    (head1),
        .count_o    (count)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if (pc_load) begin
            state_d    = ST_REQ;
            pc_d       = pc_load_addr;
            fetch_pc_d = pc_load_addr;
        end else begin
            pc_d = pc_q + 23'(pop_cnt);
            if (push) begin
                fetch_pc_d = fetch_pc_q + 23'd1;
            end
            unique case (state_q)
                // Data arriving here belongs to the previous stream.
                ST_REQ:  if (instr_fetch_started) state_d = ST_RUN;
                ST_RUN:  if (instr_fetch_stopped) state_d = ST_IDLE;
                ST_IDLE: if (count_after <= CW'(DEPTH_HW - 2)) state_d = ST_REQ;
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_ADDR;
            fetch_pc_q <= RESET_ADDR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        instr_out = 32'h0;
        if (instr_valid) begin
            instr_out = head_compressed ? {16'h0, head0} : {head1, head0};
        end
    end

    assign instr_compressed    = head_compressed;
    assign instr_pc            = pc_q;
    assign instr_addr          = fetch_pc_q;
    assign instr_fetch_restart = (state_q == ST_REQ);
    // Two entries of slack cover halfwords already in flight.
    assign instr_fetch_stall   = (state_q == ST_RUN) && (count >= CW'(DEPTH_HW - 2));

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
module tb_tinyqv_instr_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pc_load;
    logic [22:0] pc_load_addr;
    logic        instr_take;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_compressed;
    logic [22:0] instr_pc;
    logic [22:0] instr_addr;
    logic        instr_fetch_restart;
    logic        instr_fetch_stall;
    logic        instr_fetch_started;
    logic        instr_fetch_stopped;
    logic [15:0] instr_data;
    logic        instr_ready;

    always #5 clk = ~clk;

    tinyqv_instr_prefetch #(
        .DEPTH_HW  (DEPTH),
        .RESET_ADDR(23'h0)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .pc_load            (pc_load),
        .pc_load_addr       (pc_load_addr),
        .instr_take         (instr_take),
        .instr_out          (instr_out),
        .instr_valid        (instr_valid),
        .instr_compressed   (instr_compressed),
        .instr_pc           (instr_pc),
        .instr_addr         (instr_addr),
        .instr_fetch_restart(instr_fetch_restart),
        .instr_fetch_stall  (instr_fetch_stall),
        .instr_fetch_started(instr_fetch_started),
        .instr_fetch_stopped(instr_fetch_stopped),
        .instr_data         (instr_data),
        .instr_ready        (instr_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MS_IDLE = 0;
    localparam int MS_REQ  = 1;
    localparam int MS_RUN  = 2;

    logic [15:0] mq[$];
    logic [22:0] m_pc;
    logic [22:0] m_fpc;
    int          m_state;
    int          m_ovf = 0;

    function automatic logic exp_comp();
        if (mq.size() < 1) return 1'b0;
        return mq[0][1:0] != 2'b11;
    endfunction

    function automatic logic exp_valid();
        return (mq.size() >= 2) || exp_comp();
    endfunction

    function automatic logic [31:0] exp_out();
        if (!exp_valid()) return 32'h0;
        if (exp_comp()) return {16'h0, mq[0]};
        return {mq[1], mq[0]};
    endfunction

    always @(posedge clk or negedge rstn) begin
        int  n;
        bit  was_full;
        if (!rstn) begin
            mq.delete();
            m_pc    = 23'h0;
            m_fpc   = 23'h0;
            m_state = MS_REQ;
        end else if (pc_load) begin
            mq.delete();
            m_pc    = pc_load_addr;
            m_fpc   = pc_load_addr;
            m_state = MS_REQ;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (instr_take && exp_valid()) begin
                n = exp_comp() ? 1 : 2;
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                m_pc = m_pc + 23'(n);
            end
            if (m_state == MS_RUN && instr_ready) begin
                if (was_full) begin
                    m_ovf++;
                    $display("NOTE protocol error: instr_ready with full queue at %0t", $time);
                end else begin
                    mq.push_back(instr_data);
                    m_fpc = m_fpc + 23'd1;
                end
            end
            case (m_state)
                MS_REQ:  if (instr_fetch_started) m_state = MS_RUN;
                MS_RUN:  if (instr_fetch_stopped) m_state = MS_IDLE;
                default: if (mq.size() <= DEPTH - 2) m_state = MS_REQ;
            endcase
        end
    end

    // Single per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid()));
        chk("instr_compressed", 32'(instr_compressed), 32'(exp_comp()));
        chk("instr_out", instr_out, exp_out());
        chk("instr_pc", 32'(instr_pc), 32'(m_pc));
        chk("instr_addr", 32'(instr_addr), 32'(m_fpc));
        chk("restart", 32'(instr_fetch_restart), 32'(m_state == MS_REQ));
        chk("stall", 32'(instr_fetch_stall),
            32'(m_state == MS_RUN && mq.size() >= DEPTH - 2));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] hw, input logic stop);
        instr_ready         = 1'b1;
        instr_data          = hw;
        instr_fetch_stopped = stop;
        step();
        instr_ready         = 1'b0;
        instr_fetch_stopped = 1'b0;
        $display("tx: ready data=%h stop=%0b -> valid=%0b out=%h", hw, stop, instr_valid, instr_out);
    endtask

    task automatic start_stream();
        instr_fetch_started = 1'b1;
        step();
        instr_fetch_started = 1'b0;
        $display("tx: fetch started, addr=%h", instr_addr);
    endtask

    task automatic take1();
        instr_take = 1'b1;
        step();
        instr_take = 1'b0;
        $display("tx: take -> pc=%h out=%h valid=%0b", instr_pc, instr_out, instr_valid);
    endtask

    initial begin
        rstn                = 1'b0;
        pc_load             = 1'b0;
        pc_load_addr        = 23'h0;
        instr_take          = 1'b0;
        instr_fetch_started = 1'b0;
        instr_fetch_stopped = 1'b0;
        instr_data          = 16'h0;
        instr_ready         = 1'b0;
        step();
        step();
        chk("reset_restart", 32'(instr_fetch_restart), 32'd1);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_out", instr_out, 32'h0);
        chk("reset_addr", 32'(instr_addr), 32'h0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("restart_held", 32'(instr_fetch_restart), 32'd1);

        // First 32-bit instruction
        start_stream();
        chk("restart_after_start", 32'(instr_fetch_restart), 32'd0);
        feed(16'h0013, 1'b0);
        feed(16'h0000, 1'b0);
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_out", instr_out, 32'h0000_0013);
        chk("first_pc", 32'(instr_pc), 32'h0);
        chk("first_addr", 32'(instr_addr), 32'h2);
        take1();
        chk("after_take_valid", 32'(instr_valid), 32'd0);

        // Compressed mix from PC 0
        pc_load = 1'b1; pc_load_addr = 23'h0;
        step();
        pc_load = 1'b0;
        chk("reload_restart", 32'(instr_fetch_restart), 32'd1);
        start_stream();
        feed(16'h4501, 1'b0);
        chk("c_single_valid", 32'(instr_valid), 32'd1);
        feed(16'h0513, 1'b0);
        feed(16'h0000, 1'b0);
        chk("c_comp", 32'(instr_compressed), 32'd1);
        chk("c_out", instr_out, 32'h0000_4501);
        take1();
        chk("c_pc", 32'(instr_pc), 32'h1);
        chk("c_out2", instr_out, 32'h0000_0513);
        chk("c_comp2", 32'(instr_compressed), 32'd0);
        take1();
        chk("c_pc3", 32'(instr_pc), 32'h3);

        // Back-pressure and overflow
        chk("bp_stall0", 32'(instr_fetch_stall), 32'd0);
        feed(16'hA003, 1'b0);
        feed(16'hB000, 1'b0);
        chk("bp_stall2", 32'(instr_fetch_stall), 32'd1);
        feed(16'hC003, 1'b0);
        feed(16'hD000, 1'b0);
        chk("bp_out_full", instr_out, 32'hB000_A003);
        feed(16'hEEEE, 1'b0);
        chk("overflow_flag", 32'(m_ovf), 32'd1);
        chk("bp_out_kept", instr_out, 32'hB000_A003);
        chk("bp_addr", 32'(instr_addr), 32'h7);
        take1();
        chk("bp_out_next", instr_out, 32'hD000_C003);
        take1();

        // pc_load while running with three entries, overriding take and ready
        feed(16'h0001, 1'b0);
        feed(16'h0002, 1'b0);
        feed(16'h0003, 1'b0);
        pc_load = 1'b1; pc_load_addr = 23'h100; instr_take = 1'b1;
        instr_ready = 1'b1; instr_data = 16'h7777;
        step();
        pc_load = 1'b0; instr_take = 1'b0;
        chk("pl_valid", 32'(instr_valid), 32'd0);
        chk("pl_restart", 32'(instr_fetch_restart), 32'd1);
        chk("pl_addr", 32'(instr_addr), 32'h100);
        instr_data = 16'h1234;
        step();
        instr_ready = 1'b0;
        chk("pl_discard_valid", 32'(instr_valid), 32'd0);
        chk("pl_discard_addr", 32'(instr_addr), 32'h100);

        // Controller stop with a final halfword
        start_stream();
        feed(16'h0013, 1'b0);
        feed(16'h0000, 1'b0);
        feed(16'h0013, 1'b0);
        feed(16'h0000, 1'b1);
        chk("stop_restart", 32'(instr_fetch_restart), 32'd0);
        chk("stop_stall_idle", 32'(instr_fetch_stall), 32'd0);
        chk("stop_addr", 32'(instr_addr), 32'h104);
        step();
        chk("idle_hold", 32'(instr_fetch_restart), 32'd0);
        take1();
        chk("reissue_restart", 32'(instr_fetch_restart), 32'd1);
        chk("reissue_addr", 32'(instr_addr), 32'h104);
        chk("reissue_pc", 32'(instr_pc), 32'h102);

        // Async reset mid-stream with three entries
        start_stream();
        feed(16'h0017, 1'b0);
        chk("pre_reset_valid", 32'(instr_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("areset_restart", 32'(instr_fetch_restart), 32'd1);
        chk("areset_stall", 32'(instr_fetch_stall), 32'd0);
        chk("areset_valid", 32'(instr_valid), 32'd0);
        chk("areset_out", instr_out, 32'h0);
        chk("areset_comp", 32'(instr_compressed), 32'd0);
        chk("areset_pc", 32'(instr_pc), 32'h0);
        chk("areset_addr", 32'(instr_addr), 32'h0);
        step();
        step();
        rstn = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tinyqv_instr_prefetch.md
# tinyqv_instr_prefetch

Instruction prefetch buffer between the TinyQV core's decode stage and the memory controller's instruction port. It drives the fetch address and restart/stall controls and collects 16-bit halfwords into a small queue. It presents one aligned RV32IC instruction window (16- or 32-bit) to the core and flushes and refetches when the core loads a new PC.

## Interface
- `DEPTH_HW`, default 4: queue depth in halfwords; power of two, minimum 4.
- `RESET_ADDR`, default 23'h0: halfword address fetched after reset.

- `clk`  in  1  clock
- `rstn`  in  1  reset; asynchronous, active-low
- `pc_load`  in  1  flush the queue and restart fetch at `pc_load_addr`
- `pc_load_addr`  in  23  new PC, bits [23:1]
- `instr_take`  in  1  core consumes the current instruction; ignored unless `instr_valid`
- `instr_out`  out  32  current instruction; upper 16 bits are zero when compressed; all zero when not valid
- `instr_valid`  out  1  `instr_out` is complete
- `instr_compressed`  out  1  head halfword bits [1:0] != 2'b11
- `instr_pc`  out  23  address [23:1] of `instr_out`
- `instr_addr`  out  23  next halfword address to fetch, bits [23:1]
- `instr_fetch_restart`  out  1  request a new fetch stream from `instr_addr`
- `instr_fetch_stall`  out  1  ask the controller to hold the last byte of a halfword
- `instr_fetch_started`  in  1  controller pulse: stream started
- `instr_fetch_stopped`  in  1  controller pulse: stream ended
- `instr_data`  in  16  fetched halfword
- `instr_ready`  in  1  `instr_data` valid this cycle

## Operation
- Registers:
  - `fetch_pc` drives `instr_addr`.
  - `pc` drives `instr_pc`.
  - Queue read/write pointers and `count` (0..DEPTH_HW).
  - FSM state: IDLE, REQ, RUN.
- `instr_fetch_restart` = (state == REQ).
- FSM transitions:
  - REQ: `instr_ready` is discarded (it belongs to a stale stream). `instr_fetch_stopped` is ignored. On `instr_fetch_started`, go to RUN.
  - RUN: each `instr_ready` writes `instr_data` at the write pointer and increments `fetch_pc` by 1. On `instr_fetch_stopped`, go to IDLE; an `instr_ready` in the same cycle is still accepted.
  - IDLE: when `count` <= DEPTH_HW-2 (after this cycle's update), go to REQ with `fetch_pc` unchanged.
- `pc_load` in any state:
  - Next state is REQ.
  - `count` = 0, pointers reset.
  - `pc` = `fetch_pc` = `pc_load_addr`.
  - `pc_load` overrides `instr_take`, `instr_ready` and `instr_fetch_started` in the same cycle.
- `instr_fetch_stall` = (state == RUN) && `count` >= DEPTH_HW-2. This leaves two entries of margin for in-flight halfwords.
- Output window:
  - `instr_valid` = `count` >= 2, or `count` >= 1 && `instr_compressed`.
  - `instr_out` = {entry[rd+1], entry[rd]}, or {16'h0, entry[rd]} when compressed.
- Take:
  - `instr_take` && `instr_valid` pops 1 entry (compressed) or 2 entries, and adds 1 or 2 to `pc`.
  - Simultaneous pop and push: `count` += push − pop.
- Arithmetic: pointers are log2(DEPTH_HW) bits and wrap naturally. `pc`/`fetch_pc` are 23-bit and wrap modulo 2^23.
- Protocol error: `instr_ready` in RUN with `count` == DEPTH_HW. Flagged by a bench assertion; the data is dropped and the queue is not corrupted.

## Timing
- Reset (async, any cycle, including mid-stream):
  - state = REQ, `count` = 0, `pc` = `fetch_pc` = RESET_ADDR.
  - `instr_fetch_restart` = 1; `instr_fetch_stall` = 0; `instr_valid` = 0; `instr_out` = 0; `instr_compressed` = 0.
  - Queue storage is not reset.
- All outputs are functions of registered state, except:
  - `instr_fetch_stall` depends on `count` only (registered).
  - `instr_out`/`instr_compressed` read the queue combinationally.
- Latency: halfword accepted at edge N is visible on `instr_out` after edge N; if it completes an instruction, `instr_valid` is high in cycle N+1.
- `pc_load` at edge N: `instr_valid` = 0 and `instr_fetch_restart` = 1 from cycle N+1.
- `instr_fetch_restart` is held high until `instr_fetch_started` is sampled. There is no timeout: a controller busy with data transactions simply delays the start.

## Structure
- Shared package `tinyqv_fetch_pkg`: FSM state encoding (IDLE, REQ, RUN) and the RVC compressed-detect helper (bits [1:0] != 2'b11).
- Sub-module `tinyqv_hw_fifo`: halfword FIFO with dual-entry peek, pop-1/pop-2, push, flush and `count` output. The FSM and PC logic stay in the top level.

## Test plan
- Reset release, RESET_ADDR = 0:
  - `instr_fetch_restart` = 1 until `instr_fetch_started` pulses.
  - Feed halfwords 0x0013, 0x0000 → `instr_valid` = 1, `instr_out` = 0x00000013, `instr_pc` = 0, `instr_addr` = 2.
- Compressed mix: feed 0x4501 then 0x0513, 0x0000.
  - First window: `instr_compressed` = 1, `instr_out` = 0x00004501.
  - After take: `instr_pc` = 1, `instr_out` = 0x00000513.
- Back-pressure, DEPTH_HW = 4, no take:
  - `instr_fetch_stall` rises when `count` = 2.
  - Two more `instr_ready` are accepted (`count` = 4).
  - A fifth ready fires the overflow assertion.
- `pc_load` with `pc_load_addr` = 0x100 while in RUN with `count` = 3:
  - Next cycle: `count` = 0, restart = 1, `instr_addr` = 0x100.
  - `instr_ready` before `instr_fetch_started` is discarded.
- Controller stop: `instr_fetch_stopped` together with `instr_ready`:
  - The halfword is kept and the FSM goes to IDLE.
  - On take with `count` <= 2, REQ re-issues from the unchanged `instr_addr`.
- Async reset asserted mid-stream with `count` = 3 → all outputs return to reset values immediately, without waiting for a clock edge.
